// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_AW = 5;
    localparam int unsigned MEM_ARB_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between CPU and host requests.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise the CPU always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req_i,
    input  logic host_req_i,
    input  req_e last_winner_i,
    output req_e winner_c_o,
    output logic valid_c_o
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;
`endif

    always_comb begin
        valid_c_o  = cpu_req_i | host_req_i;
        winner_c_o = REQ_CPU;
        if (host_req_i && !cpu_req_i) begin
            winner_c_o = REQ_HOST;
        end
`ifdef MEM_ARB_RR_EN
        // On a tie, the side that did not win last time goes next.
        else if (host_req_i && cpu_req_i && (last_winner_i == REQ_CPU)) begin
            winner_c_o = REQ_HOST;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and host accesses onto a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = MEM_ARB_AW,
    parameter int unsigned DW = MEM_ARB_DW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    arb_state_e    state_q, state_d;
    req_e          winner_q, winner_d;
    req_e          last_winner_q;
    req_e          pick_winner_c;
    logic          pick_valid_c;
    logic          grant_c;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cpu_gnt_q, cpu_gnt_d;
    logic          host_gnt_q, host_gnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          host_rvalid_q, host_rvalid_d;
    logic          busy_q, busy_d;

    mem_arb_pick u_pick (
        .cpu_req_i     (cpu_req_i),
        .host_req_i    (host_req_i),
        .last_winner_i (last_winner_q),
        .winner_c_o    (pick_winner_c),
        .valid_c_o     (pick_valid_c)
    );

    assign grant_c = (state_q == IDLE) && pick_valid_c;

`ifdef MEM_ARB_RR_EN
    // Remember the most recent grant so the next tie alternates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_winner_q <= REQ_HOST;
        end else if (grant_c) begin
            last_winner_q <= pick_winner_c;
        end
    end
`else
    assign last_winner_q = REQ_HOST;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            winner_q      <= REQ_CPU;
            en_q          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            en_q          <= en_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cpu_gnt_q     <= cpu_gnt_d;
            host_gnt_q    <= host_gnt_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            busy_q        <= busy_d;
        end
    end

    // Next state plus the values every registered output takes in that state.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        en_d          = 1'b0;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cpu_gnt_d     = 1'b0;
        host_gnt_d    = 1'b0;
        cpu_rvalid_d  = 1'b0;
        host_rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d  = ACCESS;
                    winner_d = pick_winner_c;
                    en_d     = 1'b1;
                    if (pick_winner_c == REQ_HOST) begin
                        we_d       = host_we_i;
                        addr_d     = host_addr_i;
                        wdata_d    = host_wdata_i;
                        host_gnt_d = 1'b1;
                    end else begin
                        we_d      = cpu_we_i;
                        addr_d    = cpu_addr_i;
                        wdata_d   = cpu_wdata_i;
                        cpu_gnt_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d       = RESP;
                    cpu_rvalid_d  = (winner_q == REQ_CPU);
                    host_rvalid_d = (winner_q == REQ_HOST);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign mem_en_o      = en_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign cpu_gnt_o     = cpu_gnt_q;
    assign host_gnt_o    = host_gnt_q;
    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign host_rvalid_o = host_rvalid_q;
    assign cpu_rdata_o   = mem_rdata_i;
    assign host_rdata_o  = mem_rdata_i;
    assign busy_o        = busy_q;

endmodule
